mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified instruction/data memory between the multicycle CPU (control unit
//  fetch/LOAD/STORE accesses) and the debug program loader. Sequences each access with req/ack,
//  honours a memory ready handshake, enforces CPU-priority with bounded starvation, flags timeouts.
// PARAMETERS
//  ADDR_W     8   memory address width
//  DATA_W     8   memory data width
//  STARVE_MAX 4   max consecutive CPU grants while dbg_req pending before dbg must win (1..15)
//  TIMEOUT    15  max ACCESS cycles waiting for mem_ready before abort (1..255)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU access request; held high until cpu_ack
//  cpu_we     in   1       1=write (STORE), 0=read (fetch/LOAD)
//  cpu_addr   in   ADDR_W  CPU address (PC or ALUOut, per IorD)
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_ack    out  1       1-cycle pulse: CPU access complete
//  cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
//  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata   same set for debug loader
//  mem_en     out  1       memory access strobe, held until mem_ready
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid with mem_ready
//  mem_ready  in   1       memory completes current access this cycle
//  bus_err    out  1       pulses with ack when access aborted by timeout
//  owner      out  1       0=CPU, 1=DBG: owner of current/last access
//  busy       out  1       1 in ACCESS or RESP
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; all outputs 0; fairness count 0; timer 0; owner 0.
//   Reset mid-access: mem_en drops immediately; access abandoned, no ack issued.
//  States: IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE: if any req, choose winner, latch we/addr/wdata into internal regs, set owner, ->ACCESS.
//   Neither req: stay. Winner: CPU if cpu_req and not(dbg_req and fair_cnt==STARVE_MAX); else DBG.
//  fair_cnt: +1 on each CPU grant while dbg_req=1 (saturates at STARVE_MAX); clears on DBG grant
//   or whenever dbg_req=0 in IDLE.
//  ACCESS: mem_en=1, mem_we/addr/wdata from latched regs, stable for the whole state.
//   mem_ready=1 -> latch mem_rdata (0 for writes), ->RESP. Timer counts ACCESS cycles; reaching
//   TIMEOUT without mem_ready -> rdata reg=0, err flag set, ->RESP (mem_en drops).
//   mem_ready and timeout expiry in same cycle: ready wins, no error.
//  RESP: owner's ack=1 for exactly one cycle; its rdata = latched data; bus_err=err flag;
//   non-owner ack=0 and rdata=0. Then ->IDLE, timer and err flag cleared.
//  Latency: req seen in IDLE cycle N, mem_ready in cycle N+1+k -> ack in cycle N+2+k (min 3 cycles
//   req-to-ack inclusive). Back-to-back: next grant earliest in IDLE cycle after RESP.
//  Requester rule: drop req the edge after ack; req still high in IDLE is a new request.
//  Requester inputs are ignored outside IDLE; changes during ACCESS do not affect mem_* outputs.
//  mem_ready outside ACCESS ignored.
// STRUCTURE
//  Shared package/header: state encodings (ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2),
//   owner codes (OWN_CPU=1'b0, OWN_DBG=1'b1), opcode constants shared with control unit.
//  Sub-module: mem_access_timer (clear/enable/expire counter, width from TIMEOUT), used for the
//   ACCESS timeout; fairness counter and FSM stay in this module.
// TESTING
//  1 CPU read, addr=8'h10, mem_ready 1 cycle after mem_en, mem_rdata=8'hA5 -> cpu_ack 1 cycle,
//    cpu_rdata=8'hA5, mem_we=0, dbg_ack never high, bus_err=0.
//  2 CPU and DBG req same IDLE cycle, dbg_req held -> CPU wins 4 grants, 5th grant to DBG
//    (owner=1), fair_cnt back to 0; then CPU wins again.
//  3 DBG write addr=8'h3F data=8'h5C, mem_ready after 3 wait cycles -> mem_en/mem_we/addr/wdata
//    stable 4 cycles, dbg_ack once, dbg_rdata=0.
//  4 mem_ready never asserted, TIMEOUT=15 -> mem_en high exactly 15 cycles, then cpu_ack with
//    bus_err=1, cpu_rdata=0; next access completes normally with bus_err=0.
//  5 reset asserted in 2nd ACCESS cycle -> mem_en, acks, busy, owner all 0 same cycle; after
//    release, held cpu_req re-granted from IDLE, single ack.
//  6 mem_ready on same cycle as timeout expiry -> normal ack, bus_err=0, rdata=mem_rdata.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: FSM encodings, owner codes,
// fairness counter width and the memory opcodes shared with the control unit.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Holds STARVE_MAX up to 15.
  localparam int unsigned FAIR_W = 4;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester port (CPU or debug loader) and single-port memory bus bundles.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

interface mem_port_arbiter_mem_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output en, we, addr, wdata, input rdata, ready);
  modport slave  (input en, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_port_arbiter_timer.sv
// ACCESS-phase watchdog: counts enabled cycles and flags the last allowed one.
module mem_access_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire_c
);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  // Count value equals completed ACCESS cycles, so expiry marks the TIMEOUT-th cycle.
  assign expire_c = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expire_c)  cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory between CPU and debug loader:
// CPU priority with bounded debug starvation, req/ack sequencing, ready timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_port_arbiter_if.slave       cpu,
  mem_port_arbiter_if.slave       dbg,
  mem_port_arbiter_mem_if.master  mem,
  output logic                    bus_err,
  output logic                    owner,
  output logic                    busy
);
  logic [1:0]        state, state_d;
  logic [FAIR_W-1:0] fair_cnt, fair_d;
  logic              owner_d, busy_d, err_d, grant_dbg_c;
  logic              mem_en_q, mem_we_q, en_d, we_d;
  logic [ADDR_W-1:0] mem_addr_q, addr_d;
  logic [DATA_W-1:0] mem_wdata_q, wdata_d, rdata_c;
  logic              cpu_ack_q, dbg_ack_q, cpu_ack_d, dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q, cpu_rdata_d, dbg_rdata_d;
  logic              tmr_clr_c, tmr_en_c, tmr_expire_c;

  mem_access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr_c),
    .en       (tmr_en_c),
    .expire_c (tmr_expire_c)
  );

  assign mem.en    = mem_en_q;
  assign mem.we    = mem_we_q;
  assign mem.addr  = mem_addr_q;
  assign mem.wdata = mem_wdata_q;
  assign cpu.ack   = cpu_ack_q;
  assign cpu.rdata = cpu_rdata_q;
  assign dbg.ack   = dbg_ack_q;
  assign dbg.rdata = dbg_rdata_q;

  // The mem_* registers double as the latched command of the granted requester.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    fair_d      = fair_cnt;
    grant_dbg_c = 1'b0;
    en_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    rdata_c     = '0;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = '0;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = '0;
    err_d       = 1'b0;
    busy_d      = 1'b0;
    tmr_clr_c   = 1'b1;
    tmr_en_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!dbg.req) fair_d = '0;
        if (cpu.req || dbg.req) begin
          grant_dbg_c = dbg.req && (!cpu.req || fair_cnt == FAIR_W'(STARVE_MAX));
          owner_d     = grant_dbg_c ? OWN_DBG : OWN_CPU;
          if (grant_dbg_c)
            fair_d = '0;
          else if (dbg.req && fair_cnt != FAIR_W'(STARVE_MAX))
            fair_d = fair_cnt + FAIR_W'(1);
          en_d    = 1'b1;
          we_d    = grant_dbg_c ? dbg.we    : cpu.we;
          addr_d  = grant_dbg_c ? dbg.addr  : cpu.addr;
          wdata_d = grant_dbg_c ? dbg.wdata : cpu.wdata;
          busy_d  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        tmr_clr_c = 1'b0;
        tmr_en_c  = 1'b1;
        busy_d    = 1'b1;
        // Ready takes precedence over a coincident timeout.
        if (mem.ready || tmr_expire_c) begin
          rdata_c     = (mem.ready && !mem_we_q) ? mem.rdata : '0;
          cpu_ack_d   = (owner == OWN_CPU);
          dbg_ack_d   = (owner == OWN_DBG);
          cpu_rdata_d = (owner == OWN_CPU) ? rdata_c : '0;
          dbg_rdata_d = (owner == OWN_DBG) ? rdata_c : '0;
          err_d       = !mem.ready;
          state_d     = ST_RESP;
        end else begin
          en_d    = 1'b1;
          we_d    = mem_we_q;
          addr_d  = mem_addr_q;
          wdata_d = mem_wdata_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      fair_cnt    <= '0;
      owner       <= OWN_CPU;
      busy        <= 1'b0;
      bus_err     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state       <= state_d;
      fair_cnt    <= fair_d;
      owner       <= owner_d;
      busy        <= busy_d;
      bus_err     <= err_d;
      mem_en_q    <= en_d;
      mem_we_q    <= we_d;
      mem_addr_q  <= addr_d;
      mem_wdata_q <= wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected acks plus a
// behavioural memory with programmable wait states.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bus_err, owner, busy;

  mem_port_arbiter_if     #(.ADDR_W(8), .DATA_W(8)) cpu_if ();
  mem_port_arbiter_if     #(.ADDR_W(8), .DATA_W(8)) dbg_if ();
  mem_port_arbiter_mem_if #(.ADDR_W(8), .DATA_W(8)) mem_if ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk     (clk),
    .reset   (reset),
    .cpu     (cpu_if),
    .dbg     (dbg_if),
    .mem     (mem_if),
    .bus_err (bus_err),
    .owner   (owner),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         own;
    logic [7:0] rd;
    bit         err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Memory model knobs and observations
  int         mem_wait = 0;
  logic [7:0] mem_rd_val = 8'h00;
  int         en_cnt = 0;
  int         last_en_len = 0;
  bit         stable = 1'b1;
  logic       first_we;
  logic [7:0] first_addr, first_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit own, input logic [7:0] rd, input bit err);
    exp_t e;
    e.own = own; e.rd = rd; e.err = err;
    sb.push_back(e);
  endtask

  // Memory: ready in ACCESS cycle mem_wait+1 (never when mem_wait < 0)
  initial begin
    mem_if.ready = 1'b0;
    mem_if.rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        en_cnt = 0;
        mem_if.ready = 1'b0;
      end else if (mem_if.en) begin
        if (en_cnt == 0) begin
          first_we = mem_if.we; first_addr = mem_if.addr; first_wdata = mem_if.wdata;
          stable = 1'b1;
        end else if (mem_if.we !== first_we || mem_if.addr !== first_addr ||
                     mem_if.wdata !== first_wdata) begin
          stable = 1'b0;
        end
        en_cnt++;
        mem_if.rdata = mem_rd_val;
        mem_if.ready = (mem_wait >= 0) && (en_cnt == mem_wait + 1);
      end else begin
        if (en_cnt != 0) last_en_len = en_cnt;
        en_cnt = 0;
        mem_if.ready = 1'b0;
      end
    end
  end

  // Monitor: every ack is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (cpu_if.ack || dbg_if.ack)) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {30'd0, cpu_if.ack, dbg_if.ack}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_sel", {30'd0, cpu_if.ack, dbg_if.ack}, e.own ? 32'd1 : 32'd2);
          check("owner_rdata", e.own ? dbg_if.rdata : cpu_if.rdata, {24'd0, e.rd});
          check("other_rdata", e.own ? cpu_if.rdata : dbg_if.rdata, 32'd0);
          check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
          check("owner", {31'd0, owner}, {31'd0, e.own});
          check("busy_resp", {31'd0, busy}, 32'd1);
        end
      end else if (reset && bus_err !== 1'b0) begin
        check("stray_bus_err", {31'd0, bus_err}, 32'd0);
      end
    end
  end

  // One access by a single requester; lat = negedges from request to ack inclusive
  task automatic do_access(input bit use_dbg, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, input int wait_c,
                           input logic [7:0] rd, input logic [7:0] exp_rd,
                           input bit exp_err, output int lat);
    bit got = 1'b0;
    mem_wait = wait_c;
    mem_rd_val = rd;
    push(use_dbg, exp_rd, exp_err);
    lat = 0;
    @(posedge clk); #1;
    if (use_dbg) begin
      dbg_if.we = we; dbg_if.addr = addr; dbg_if.wdata = wdata; dbg_if.req = 1'b1;
    end else begin
      cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.req = 1'b1;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = use_dbg ? dbg_if.ack : cpu_if.ack;
    end
    if (!got) check("ack_wait_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    dbg_if.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running expected done");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  dbg_done;
    bit  done;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = 8'h00; cpu_if.wdata = 8'h00;
    dbg_if.req = 1'b0; dbg_if.we = 1'b0; dbg_if.addr = 8'h00; dbg_if.wdata = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_mem_en", {31'd0, mem_if.en}, 32'd0);
    check("rst_acks", {30'd0, cpu_if.ack, dbg_if.ack}, 32'd0);
    check("rst_busy_owner_err", {29'd0, busy, owner, bus_err}, 32'd0);
    check("rst_rdata", {16'd0, cpu_if.rdata, dbg_if.rdata}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: CPU read, ready in second ACCESS cycle
    do_access(1'b0, 1'b0, 8'h10, 8'h00, 1, 8'hA5, 8'hA5, 1'b0, lat);
    check("t1_latency", lat, 32'd4);
    check("t1_en_len", last_en_len, 32'd2);
    check("t1_cmd", {15'd0, first_we, first_addr, first_wdata}, {15'd0, 1'b0, 8'h10, 8'h00});

    // 2: simultaneous requests, debug held -> 4 CPU grants then DBG, then CPU again
    mem_wait = 0;
    mem_rd_val = 8'h11;
    for (int i = 0; i < 4; i++) push(1'b0, 8'h11, 1'b0);
    push(1'b1, 8'h11, 1'b0);
    push(1'b0, 8'h11, 1'b0);
    @(posedge clk); #1;
    cpu_if.we = 1'b0; cpu_if.addr = 8'h20; cpu_if.req = 1'b1;
    dbg_if.we = 1'b0; dbg_if.addr = 8'h30; dbg_if.req = 1'b1;
    dbg_done = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (dbg_if.ack) begin
        dbg_done = 1'b1;
        @(posedge clk); #1;
        dbg_if.req = 1'b0;
      end else if (cpu_if.ack && dbg_done) begin
        @(posedge clk); #1;
        cpu_if.req = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) check("t2_timeout", 32'd0, 32'd1);
    cpu_if.req = 1'b0;
    dbg_if.req = 1'b0;
    check("t2_sb_drained", sb.size(), 32'd0);

    // 3: DBG write with 3 wait cycles
    do_access(1'b1, 1'b1, 8'h3F, 8'h5C, 3, 8'hEE, 8'h00, 1'b0, lat);
    check("t3_latency", lat, 32'd6);
    check("t3_en_len", last_en_len, 32'd4);
    check("t3_stable", {31'd0, stable}, 32'd1);
    check("t3_cmd", {15'd0, first_we, first_addr, first_wdata}, {15'd0, 1'b1, 8'h3F, 8'h5C});

    // 4: no ready -> timeout after 15 ACCESS cycles, then a clean access
    do_access(1'b0, 1'b0, 8'h44, 8'h00, -1, 8'h77, 8'h00, 1'b1, lat);
    check("t4_en_len", last_en_len, 32'd15);
    do_access(1'b0, 1'b0, 8'h45, 8'h00, 0, 8'h3C, 8'h3C, 1'b0, lat);
    check("t4_recover_latency", lat, 32'd3);

    // 5: reset during the second ACCESS cycle
    mem_wait = -1;
    @(posedge clk); #1;
    cpu_if.we = 1'b0; cpu_if.addr = 8'h66; cpu_if.req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("t5_pre_en", {31'd0, mem_if.en}, 32'd1);
    reset = 1'b0;
    #1;
    check("t5_en", {31'd0, mem_if.en}, 32'd0);
    check("t5_acks", {30'd0, cpu_if.ack, dbg_if.ack}, 32'd0);
    check("t5_busy_owner", {30'd0, busy, owner}, 32'd0);
    mem_wait = 0;
    mem_rd_val = 8'h5A;
    push(1'b0, 8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = cpu_if.ack;
    end
    if (!done) check("t5_regrant_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_sb_drained", sb.size(), 32'd0);

    // 6: ready coincides with the timeout cycle
    do_access(1'b0, 1'b0, 8'h55, 8'h00, 14, 8'h96, 8'h96, 1'b0, lat);
    check("t6_en_len", last_en_len, 32'd15);
    check("t6_latency", lat, 32'd17);

    repeat (5) @(negedge clk);
    check("final_sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
